// File: rtl/credit_dispense_fsm_if.sv
// Panel-side bundle for the credit/dispense controller:
// coin/req/cancel inputs and actuator/status outputs.
interface credit_dispense_fsm_if #(
    parameter int CREDIT_W = 4
);
    logic                coin1;
    logic                coin2;
    logic                req;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                refund;
    logic [CREDIT_W-1:0] refund_amt;
    logic                coin_reject;
    logic                busy;
    logic [1:0]          status;

    modport master (
        output coin1, coin2, req, cancel,
        input  credit, dispense, refund, refund_amt,
        input  coin_reject, busy, status
    );

    modport slave (
        input  coin1, coin2, req, cancel,
        output credit, dispense, refund, refund_amt,
        output coin_reject, busy, status
    );
endinterface

// File: rtl/credit_dispense_fsm.sv
// Credit-accumulating dispense controller: saturating coin credit,
// timed dispense pulse, cancel/timeout refund strobe.
module credit_dispense_fsm #(
    parameter int CREDIT_W    = 4,
    parameter int COIN1_VAL   = 1,
    parameter int COIN2_VAL   = 2,
    parameter int PRICE       = 3,
    parameter int MAX_CREDIT  = 7,
    parameter int DISP_CYCLES = 4,
    parameter int TIMEOUT     = 16
) (
    input logic                 clk,
    input logic                 reset,
    credit_dispense_fsm_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CREDIT   = 2'b01,
        DISPENSE = 2'b10,
        REFUND   = 2'b11
    } state_e;

    localparam int SW = CREDIT_W + 1;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int DW = (DISP_CYCLES < 2) ? 1 : $clog2(DISP_CYCLES);

    localparam logic [SW-1:0] C1_V    = SW'(COIN1_VAL);
    localparam logic [SW-1:0] C2_V    = SW'(COIN2_VAL);
    localparam logic [SW-1:0] MAX_V   = SW'(MAX_CREDIT);
    localparam logic [SW-1:0] PRICE_V = SW'(PRICE);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(DISP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic                rej_q, rej_d;

    logic [SW-1:0] sum;
    logic [SW-1:0] total;
    logic [SW-1:0] spend;
    logic          coin_any;
    logic          coin_ok;
    logic          can_buy;

    // Coins in one cycle are accepted or refused as a group.
    always_comb begin
        sum      = (bus.coin1 ? C1_V : '0) + (bus.coin2 ? C2_V : '0);
        total    = {1'b0, credit_q} + sum;
        coin_any = bus.coin1 | bus.coin2;
        coin_ok  = coin_any && (total <= MAX_V);
        can_buy  = ({1'b0, credit_q} >= PRICE_V);
        spend    = (coin_ok ? total : {1'b0, credit_q}) - PRICE_V;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        dcnt_d   = dcnt_q;
        rej_d    = coin_any;
        unique case (state_q)
            IDLE: begin
                rej_d = coin_any && !coin_ok;
                if (coin_ok) begin
                    credit_d = total[CREDIT_W-1:0];
                    timer_d  = '0;
                    state_d  = CREDIT;
                end
            end
            CREDIT: begin
                if (bus.cancel) begin
                    state_d = REFUND;
                end else begin
                    rej_d = coin_any && !coin_ok;
                    if (bus.req && can_buy) begin
                        credit_d = spend[CREDIT_W-1:0];
                        dcnt_d   = '0;
                        state_d  = DISPENSE;
                    end else if (coin_ok) begin
                        credit_d = total[CREDIT_W-1:0];
                        timer_d  = '0;
                    end else if (TIMEOUT != 0 && timer_q == TO_LAST) begin
                        state_d = REFUND;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            DISPENSE: begin
                if (dcnt_q == D_LAST) begin
                    timer_d = '0;
                    state_d = (credit_q == '0) ? IDLE : CREDIT;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            REFUND: begin
                credit_d = '0;
                timer_d  = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            timer_q  <= '0;
            dcnt_q   <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            dcnt_q   <= dcnt_d;
            rej_q    <= rej_d;
        end
    end

    assign bus.credit      = credit_q;
    assign bus.dispense    = (state_q == DISPENSE);
    assign bus.refund      = (state_q == REFUND);
    assign bus.refund_amt  = (state_q == REFUND) ? credit_q : '0;
    assign bus.coin_reject = rej_q;
    assign bus.busy        = state_q[1];
    assign bus.status      = state_q;
endmodule

// File: doc/credit_dispense_fsm.md
# credit_dispense_fsm

Parametrised credit-accumulating dispense controller, the next generation of the two-input coin/paid-access FSM pair. Two coin inputs with configurable values feed a saturating credit register. A request spends PRICE credits and drives a timed dispense pulse. Cancel or an idle timeout returns the remaining credit as a one-cycle refund. It sits between debounced panel inputs and the actuator/status outputs on `uo_out`.

## Interface
Parameters:
- `CREDIT_W`, default 4: width of the credit register and `refund_amt`.
- `COIN1_VAL`, default 1: credit units added by `coin1`.
- `COIN2_VAL`, default 2: credit units added by `coin2`.
- `PRICE`, default 3: credit units consumed per dispense; must be ≥1.
- `MAX_CREDIT`, default 7: credit cap; must be ≤ 2^CREDIT_W−1 and ≥ PRICE.
- `DISP_CYCLES`, default 4: cycles `dispense` stays high; must be ≥1.
- `TIMEOUT`, default 16: idle cycles in CREDIT before auto-refund; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `coin1` in 1: one-cycle coin pulse, value COIN1_VAL.
- `coin2` in 1: one-cycle coin pulse, value COIN2_VAL.
- `req` in 1: dispense request, sampled each cycle.
- `cancel` in 1: refund request, sampled each cycle.
- `credit` out CREDIT_W: current credit register.
- `dispense` out 1: actuator drive.
- `refund` out 1: one-cycle refund strobe.
- `refund_amt` out CREDIT_W: amount refunded; valid only while `refund` is high, 0 otherwise.
- `coin_reject` out 1: one-cycle strobe for a refused coin.
- `busy` out 1: high in DISPENSE and REFUND.
- `status` out 2: state encoding.

## Operation
- State encoding: IDLE=00, CREDIT=01, DISPENSE=10, REFUND=11. `status` equals the state register; all outputs except `coin_reject` are Moore outputs.
- Coin acceptance (IDLE/CREDIT only): sum = COIN1_VAL·coin1 + COIN2_VAL·coin2, computed at CREDIT_W+1 bits.
  - If credit+sum ≤ MAX_CREDIT, all coins in that cycle are added.
  - Otherwise all coins in that cycle are refused and credit is unchanged.
- Coins are always refused in DISPENSE and REFUND, and in any cycle where `cancel` is accepted.
- IDLE: credit = 0. Any accepted coin → CREDIT. `req` and `cancel` are ignored.
- CREDIT, evaluated in priority order:
  1. `cancel` → REFUND.
  2. `req` with registered credit ≥ PRICE → DISPENSE. Credit becomes credit − PRICE + (accepted coin sum).
  3. `req` with credit < PRICE is ignored.
  4. Timeout expiry → REFUND.
- Timeout timer:
  - Cleared on entry to CREDIT and on any accepted coin.
  - Increments on every other CREDIT cycle.
  - REFUND is entered on the edge ending the TIMEOUT-th consecutive idle cycle. An ignored `req` does not clear the timer.
- DISPENSE: `dispense`=1 and `busy`=1 for exactly DISP_CYCLES cycles. On exit: credit = 0 → IDLE; otherwise → CREDIT with the timer cleared.
- REFUND: lasts one cycle with `refund`=1, `refund_amt`=credit, `busy`=1. Next edge: credit ← 0, state → IDLE.
- `coin_reject`: registered; high for one cycle after any cycle in which at least one coin pulse was refused.

## Timing
- Reset values: state IDLE, credit 0, timer 0, dispense-cycle counter 0. `dispense`, `refund`, `refund_amt`, `coin_reject`, `busy` = 0. `status` = 00.
- Assertion of `reset` clears all state immediately (asynchronous) regardless of clock. Reset during DISPENSE drops `dispense` at once. No refund is issued for credit lost to reset.
- Coin to `credit` update: 1 cycle.
- `req` to `dispense` high: 1 cycle. `dispense` falls DISP_CYCLES cycles after it rises.
- `cancel` to `refund`: 1 cycle. `credit` reads 0 the cycle after `refund`.
- Back-to-back: a `req` in the first CREDIT cycle after DISPENSE is honoured if credit ≥ PRICE.

## Test plan
All scenarios use default parameters.
1. `coin2`, then `coin1`, then `req` → credit reads 2, then 3. `dispense` is high for 4 cycles starting 1 cycle after `req`. Credit then 0, status 00.
2. Three `coin2` pulses (credit 6), then `req` → dispense 4 cycles, credit 3, status 01. A second `req` → dispense again, then IDLE.
3. Credit 6 plus `coin2` → `coin_reject` pulses and credit stays 6. At credit 4, `coin1`+`coin2` in the same cycle → credit 7, no reject. A coin during DISPENSE → reject.
4. Credit 3, then `cancel` and `req` in the same cycle → `refund`=1 for one cycle with `refund_amt`=3, no dispense. Credit then 0, IDLE.
5. Credit 2 with `req` every 4 cycles → no dispense. After 16 cycles with no coins → `refund` with `refund_amt`=2.
6. `reset` asserted in the 2nd DISPENSE cycle with credit 3 remaining → `dispense` low immediately. Credit 0, status 00, no `refund` pulse after release.
